// File: rtl/exibe_leds.sv
// Timed LED presentation stage: captures the multiplexer value on request, shows it
// for T_ON cycles, blanks for T_OFF cycles, then pulses pronto for one cycle.
module exibe_leds #(
    parameter int T_ON  = 500,
    parameter int T_OFF = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] dado,
    input  logic       mostra,
    input  logic       cancela,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [1:0] db_estado
);

    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int CW    = ($clog2(T_MAX + 1) < 1) ? 1 : $clog2(T_MAX + 1);

    localparam logic [CW-1:0] LAST_ON  = CW'(T_ON - 1);
    localparam logic [CW-1:0] LAST_OFF = (T_OFF > 0) ? CW'(T_OFF - 1) : '0;

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        EXIBE  = 2'b01,
        APAGA  = 2'b10,
        FIM    = 2'b11
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic [3:0]    dado_reg;

    // Outputs are registered alongside the state, so each branch sets them to the
    // values belonging to the state being entered.
    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; blocking assignments would create order-dependent behaviour.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            cnt      <= '0;
            dado_reg <= '0;
            leds     <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (mostra && !cancela) begin
                        dado_reg <= dado;
                        cnt      <= '0;
                        estado   <= EXIBE;
                        leds     <= dado;
                        ocupado  <= 1'b1;
                    end
                end

                EXIBE: begin
                    if (cancela) begin
                        estado  <= OCIOSO;
                        cnt     <= '0;
                        leds    <= '0;
                        ocupado <= 1'b0;
                    end else if (cnt == LAST_ON) begin
                        cnt  <= '0;
                        leds <= '0;
                        // A zero-length blank phase goes straight to completion.
                        if (T_OFF > 0) begin
                            estado <= APAGA;
                        end else begin
                            estado <= FIM;
                            pronto <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt + CW'(1);
                        leds <= dado_reg;
                    end
                end

                APAGA: begin
                    if (cancela) begin
                        estado  <= OCIOSO;
                        cnt     <= '0;
                        ocupado <= 1'b0;
                    end else if (cnt == LAST_OFF) begin
                        cnt    <= '0;
                        estado <= FIM;
                        pronto <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                FIM: begin
                    estado  <= OCIOSO;
                    leds    <= '0;
                    ocupado <= 1'b0;
                    pronto  <= 1'b0;
                end

                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    assign db_estado = estado;

endmodule
